ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller in front of a single-port synchronous RAM.
// A one-entry output register is prefetched from the RAM, so up to DEPTH+1
// words are held in total. Reads take priority over writes for the RAM port.
// Optional feature: define RAM_FIFO_CTRL_ALMOST_FULL_EN to add the registered
// almost_full output (count >= AF_LEVEL).
//
// state  | meaning
// S_IDLE | no read in flight; a prefetch read or a write may use the RAM
// S_RD   | read issued last cycle; ram_dout is captured into rd_data
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  rd_go;
  logic                  wr_fire;

  // RAM port arbitration: prefetch read wins, write fills remaining cycles
  always_comb begin
    rd_go     = !rst && (state == S_IDLE) && !rd_valid && (count != '0);
    wr_ready  = !rst && (count < DEPTH_CNT) && !rd_go;
    wr_fire   = wr_valid && wr_ready;
    ram_we    = wr_fire;
    ram_re    = rd_go;
    ram_addr  = '0;
    ram_din   = '0;
    count_nxt = count;
    if (wr_fire) begin
      ram_addr  = wr_ptr;
      ram_din   = wr_data;
      count_nxt = count + 1'b1;
    end else if (rd_go) begin
      ram_addr  = rd_ptr;
      count_nxt = count - 1'b1;
    end
  end

  // Pointers, occupancy and the read FSM with its output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      count <= count_nxt;
      if (wr_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_go)
        rd_ptr <= rd_ptr + 1'b1;
      case (state)
        S_IDLE: begin
          if (rd_valid && rd_ready)
            rd_valid <= 1'b0;
          if (rd_go)
            state <= S_RD;
        end
        S_RD: begin
          // rd_valid is always low here, so no consume can collide with the load
          rd_data  <= ram_dout;
          rd_valid <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);

  // Registered from the next count so it tracks count without a cycle of lag
  always_ff @(posedge clk) begin
    if (rst)
      almost_full <= 1'b0;
    else
      almost_full <= (count_nxt >= AF_CNT);
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a registered-read RAM model and a
// scoreboard of accepted words checked against the output handshake.
// Build with RAM_FIFO_CTRL_ALMOST_FULL_EN defined to also cover almost_full.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
  logic       almost_full;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_LEVEL(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .count(count),
    .ram_we(ram_we),
    .ram_re(ram_re),
    .ram_addr(ram_addr),
    .ram_din(ram_din),
    .ram_dout(ram_dout)
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    ,
    .almost_full(almost_full)
`endif
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int         we_addr_q [$];
  int         we_cyc_q [$];
  int         re_addr_q [$];
  int         re_cyc_q [$];
  int         acc_cnt = 0;
  int         last_re_cyc = 0;
  logic       prev_rv = 1'b0;

  // Single-port RAM: registered read data held until the next read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we)
      mem[ram_addr] <= ram_din;
    if (ram_re)
      ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_cyc_q.delete();
    re_addr_q.delete();
    re_cyc_q.delete();
    acc_cnt = 0;
  endtask

  // Offer one word and hold it until the controller takes it
  task automatic push(input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", wr_ready, 1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || rd_valid || count != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", (n < 300), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: logs RAM traffic, fills and drains the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_rv = 1'b0;
      end else begin
        if (ram_we || ram_re)
          check("we_re_exclusive", ram_we & ram_re, 0);
        if (ram_we) begin
          we_addr_q.push_back(int'(ram_addr));
          we_cyc_q.push_back(cyc);
        end
        if (ram_re) begin
          re_addr_q.push_back(int'(ram_addr));
          re_cyc_q.push_back(cyc);
          last_re_cyc = cyc;
        end
        if (wr_valid && wr_ready) begin
          exp_q.push_back(wr_data);
          acc_cnt++;
        end
        if (rd_valid && !prev_rv)
          check("rd_valid_latency", cyc - last_re_cyc, 2);
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0)
            check("rd_unexpected_word", 1, 0);
          else
            check("rd_data_order", rd_data, exp_q.pop_front());
        end
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
        if (count == 5'd12)
          check("almost_full_at_12", almost_full, 1);
        if (count == 5'd11)
          check("almost_full_at_11", almost_full, 0);
`endif
        prev_rv = rd_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  disc;
    int  wrap;
    logic wrap_done;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    rd_ready = 1'b0;
    wrap_done = 1'b0;

    // Reset with random inputs
    repeat (2) begin
      @(posedge clk);
      #1;
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_re", ram_re, 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_ram_we_after", ram_we, 0);
    check("rst_ram_re_after", ram_re, 0);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    check("rst_almost_full", almost_full, 0);
`endif
    @(posedge clk);
    #1;

    // Order: AA, BB, CC with downstream always ready
    clear_logs();
    rd_ready = 1'b1;
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    drain();
    check("order_nwrites", we_addr_q.size(), 3);
    if (we_addr_q.size() >= 3) begin
      check("order_addr0", we_addr_q[0], 0);
      check("order_addr1", we_addr_q[1], 1);
      check("order_addr2", we_addr_q[2], 2);
    end
    if (we_cyc_q.size() >= 1 && re_cyc_q.size() >= 1)
      check("first_read_latency", re_cyc_q[0] - we_cyc_q[0], 1);
    check("order_rd_data_held", rd_data, 8'hCC);

    // Full: downstream stalled, 17 words fit
    clear_logs();
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      push(8'h10 + 8'(i));
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    repeat (4) @(negedge clk);
    check("full_wr_ready", wr_ready, 0);
    check("full_count", count, 16);
    check("full_accepted", acc_cnt, 17);
    check("full_rd_valid", rd_valid, 1);
    check("full_rd_data_first", rd_data, 8'h10);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    check("full_almost_full", almost_full, 1);
`endif
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    drain();
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    check("drained_almost_full", almost_full, 0);
`endif

    // Contention: write held while the prefetch read fires (wr_ptr now 4)
    clear_logs();
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    @(negedge clk);
    check("cont_c0_wr_ready", wr_ready, 1);
    check("cont_c0_we", ram_we, 1);
    check("cont_c0_addr", ram_addr, 4);
    @(posedge clk);
    #1;
    wr_data = 8'hA5;
    @(negedge clk);
    check("cont_c1_re", ram_re, 1);
    check("cont_c1_wr_ready", wr_ready, 0);
    check("cont_c1_we", ram_we, 0);
    check("cont_c1_addr", ram_addr, 4);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("cont_c2_wr_ready", wr_ready, 1);
    check("cont_c2_we", ram_we, 1);
    check("cont_c2_addr", ram_addr, 5);
    check("cont_c2_din", ram_din, 8'hA5);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    drain();

    // Wrap: 40 words with random downstream stalls
    clear_logs();
    fork
      begin
        for (int i = 0; i < 40; i++)
          push(8'h80 + 8'(i));
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          @(posedge clk);
          #1;
          rd_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rd_ready = 1'b1;
    drain();
    check("wrap_accepted", acc_cnt, 40);
    check("wrap_reads", re_addr_q.size(), 40);
    disc = 0;
    wrap = 0;
    for (int i = 1; i < we_addr_q.size(); i++) begin
      if (we_addr_q[i] != (we_addr_q[i-1] + 1) % 16)
        disc++;
      if (we_addr_q[i-1] == 15 && we_addr_q[i] == 0)
        wrap = 1;
    end
    for (int i = 1; i < re_addr_q.size(); i++) begin
      if (re_addr_q[i] != (re_addr_q[i-1] + 1) % 16)
        disc++;
    end
    check("wrap_ptr_continuity", disc, 0);
    check("wrap_seen_15_to_0", wrap, 1);

    // Reset while the read is in flight
    clear_logs();
    rd_ready = 1'b0;
    push(8'h77);
    @(negedge clk);
    check("midrst_read_issued", ram_re, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_wr_ready", wr_ready, 1);
    repeat (3) @(negedge clk);
    check("midrst_rd_valid_stays", rd_valid, 0);
    check("midrst_no_read", re_addr_q.size(), 1);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    push(8'h11);
    drain();
    check("midrst_readback", rd_data, 8'h11);
    check("midrst_write_addr0", (we_addr_q.size() == 2) ? we_addr_q[1] : -1, 0);
    repeat (3) @(negedge clk);
    check("empty_no_read", re_addr_q.size(), 2);
    check("empty_rd_data_held", rd_data, 8'h11);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
